// File: rtl/word_pair_sender_if.sv
// Two independent valid/ready word channels carrying a 32-bit word pair.
// The master drives data and valid, and the slave drives ready.
interface word_pair_sender_if;
  logic [31:0] out1;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out2;
  logic        out2_valid;
  logic        out2_ready;

  modport master (
    output out1, out1_valid, out2, out2_valid,
    input  out1_ready, out2_ready
  );

  modport slave (
    input  out1, out1_valid, out2, out2_valid,
    output out1_ready, out2_ready
  );
endinterface

// File: rtl/word_pair_sender.sv
// Burst traffic source. Pair k carries seed+k on channel 1 and ~(seed+k) on
// channel 2. Each channel completes its own handshake, and the next pair is
// issued only once both halves of the current pair have gone out.
module word_pair_sender #(
  parameter int GAP = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                length,
  input  logic [31:0]               seed,
  word_pair_sender_if.master        ch,
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                led
);

  typedef enum logic [1:0] {IDLE, SEND, GAP_WAIT, DONE_S} state_t;

  localparam logic [3:0] LED_IDLE = 4'b0001;
  localparam logic [3:0] LED_GAP  = 4'b0010;
  localparam logic [3:0] LED_SEND = 4'b0100;
  localparam logic [3:0] LED_DONE = 4'b1000;

  // Gap counter holds GAP-1 down to 0; sized for at least one bit so GAP=0 still elaborates.
  localparam int             GCW      = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? (GAP - 1) : 0);

  state_t         state_reg;
  logic [7:0]     len_reg;
  logic [31:0]    seed_reg;
  logic [7:0]     k_reg;
  logic [GCW-1:0] gap_cnt_reg;
  logic [31:0]    out1_reg;
  logic [31:0]    out2_reg;
  logic           v1_reg;
  logic           v2_reg;
  logic           busy_reg;
  logic           done_reg;
  logic [3:0]     led_reg;

  logic [7:0]  k_inc;
  logic [31:0] cur_word;
  logic [31:0] next_word;
  logic        pair_done;

  assign k_inc     = k_reg + 8'd1;
  assign cur_word  = seed_reg + {24'd0, k_reg};
  assign next_word = seed_reg + {24'd0, k_inc};
  // In SEND a low valid means that channel already transferred this pair.
  assign pair_done = (~v1_reg | ch.out1_ready) & (~v2_reg | ch.out2_ready);

  assign ch.out1       = out1_reg;
  assign ch.out2       = out2_reg;
  assign ch.out1_valid = v1_reg;
  assign ch.out2_valid = v2_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign led           = led_reg;

  // Burst sequencer: all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      len_reg     <= 8'd0;
      seed_reg    <= 32'd0;
      k_reg       <= 8'd0;
      gap_cnt_reg <= '0;
      out1_reg    <= 32'd0;
      out2_reg    <= 32'd0;
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      led_reg     <= LED_IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg  <= length;
            seed_reg <= seed;
            k_reg    <= 8'd0;
            busy_reg <= 1'b1;
            if (length == 8'd0) begin
              state_reg <= DONE_S;
              done_reg  <= 1'b1;
              led_reg   <= LED_DONE;
            end else begin
              state_reg <= SEND;
              out1_reg  <= seed;
              out2_reg  <= ~seed;
              v1_reg    <= 1'b1;
              v2_reg    <= 1'b1;
              led_reg   <= LED_SEND;
            end
          end
        end

        SEND: begin
          if (v1_reg && ch.out1_ready) v1_reg <= 1'b0;
          if (v2_reg && ch.out2_ready) v2_reg <= 1'b0;
          if (pair_done) begin
            if (k_inc == len_reg) begin
              state_reg <= DONE_S;
              done_reg  <= 1'b1;
              led_reg   <= LED_DONE;
            end else begin
              k_reg <= k_inc;
              if (GAP > 0) begin
                state_reg   <= GAP_WAIT;
                gap_cnt_reg <= GAP_LAST;
                led_reg     <= LED_GAP;
              end else begin
                // Back-to-back: next pair replaces the one just completed.
                out1_reg <= next_word;
                out2_reg <= ~next_word;
                v1_reg   <= 1'b1;
                v2_reg   <= 1'b1;
              end
            end
          end
        end

        GAP_WAIT: begin
          if (gap_cnt_reg == '0) begin
            state_reg <= SEND;
            out1_reg  <= cur_word;
            out2_reg  <= ~cur_word;
            v1_reg    <= 1'b1;
            v2_reg    <= 1'b1;
            led_reg   <= LED_SEND;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GCW'(1);
          end
        end

        DONE_S: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          led_reg   <= LED_IDLE;
        end

        default: begin
          state_reg <= IDLE;
          led_reg   <= LED_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_pair_sender.sv
// Bench for word_pair_sender: one instance with GAP=4 (index 0), one with GAP=0 (index 1).
module tb_word_pair_sender;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   cmp = 0;
  int   err = 0;

  logic [1:0]  start_v = 2'b00;
  logic [7:0]  len_v [2];
  logic [31:0] seed_v [2];
  logic [1:0]  r1 = 2'b11;
  logic [1:0]  r2 = 2'b11;

  logic [1:0]  v1, v2, busy_o, done_o;
  logic [31:0] o1 [2];
  logic [31:0] o2 [2];
  logic [3:0]  led_o [2];

  word_pair_sender_if ch_a ();
  word_pair_sender_if ch_b ();

  assign ch_a.out1_ready = r1[0];
  assign ch_a.out2_ready = r2[0];
  assign ch_b.out1_ready = r1[1];
  assign ch_b.out2_ready = r2[1];
  assign v1[0] = ch_a.out1_valid;
  assign v2[0] = ch_a.out2_valid;
  assign v1[1] = ch_b.out1_valid;
  assign v2[1] = ch_b.out2_valid;
  assign o1[0] = ch_a.out1;
  assign o2[0] = ch_a.out2;
  assign o1[1] = ch_b.out1;
  assign o2[1] = ch_b.out2;

  word_pair_sender #(.GAP(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .length(len_v[0]), .seed(seed_v[0]),
    .ch(ch_a), .busy(busy_o[0]), .done(done_o[0]), .led(led_o[0])
  );

  word_pair_sender #(.GAP(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .length(len_v[1]), .seed(seed_v[1]),
    .ch(ch_b), .busy(busy_o[1]), .done(done_o[1]), .led(led_o[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every transfer, counts done pulses and busy cycles,
  // and flags any valid that drops or any data that changes before its transfer.
  int          xd[$];
  int          xc[$];
  int          xcyc[$];
  logic [31:0] xdata[$];
  int          done_cnt [2];
  int          busy_cyc [2];
  int          stab_err = 0;
  logic        pv1 [2];
  logic        pv2 [2];
  logic        pf1 [2];
  logic        pf2 [2];
  logic [31:0] pd1 [2];
  logic [31:0] pd2 [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      done_cnt[d] = 0; busy_cyc[d] = 0; pv1[d] = 0; pv2[d] = 0;
      pf1[d] = 0; pf2[d] = 0; pd1[d] = 0; pd2[d] = 0;
      len_v[d] = 0; seed_v[d] = 0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        pv1[d] = 1'b0;
        pv2[d] = 1'b0;
      end else begin
        if (pv1[d] && !pf1[d] && (!v1[d] || o1[d] !== pd1[d])) stab_err++;
        if (pv2[d] && !pf2[d] && (!v2[d] || o2[d] !== pd2[d])) stab_err++;
        if (v1[d] && r1[d]) begin xd.push_back(d); xc.push_back(1); xcyc.push_back(cyc); xdata.push_back(o1[d]); end
        if (v2[d] && r2[d]) begin xd.push_back(d); xc.push_back(2); xcyc.push_back(cyc); xdata.push_back(o2[d]); end
        if (done_o[d]) done_cnt[d]++;
        if (busy_o[d]) busy_cyc[d]++;
        pv1[d] = v1[d]; pd1[d] = o1[d]; pf1[d] = v1[d] && r1[d];
        pv2[d] = v2[d]; pd2[d] = o2[d]; pf2[d] = v2[d] && r2[d];
      end
    end
  end

  // Raises start for exactly one sampling edge; returns just after that edge.
  task automatic pulse_start(input int d, input logic [31:0] s, input logic [7:0] l);
    @(posedge clk); #1;
    start_v[d] = 1'b1; seed_v[d] = s; len_v[d] = l;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cmp++; if (o1[d] !== 32'd0) begin err++; $display("FAIL reset_out1[%0d]: got %h expected 0", d, o1[d]); end
      cmp++; if (o2[d] !== 32'd0) begin err++; $display("FAIL reset_out2[%0d]: got %h expected 0", d, o2[d]); end
      cmp++; if ({v1[d], v2[d]} !== 2'b00) begin err++; $display("FAIL reset_valid[%0d]: got %b expected 00", d, {v1[d], v2[d]}); end
      cmp++; if ({busy_o[d], done_o[d]} !== 2'b00) begin err++; $display("FAIL reset_busy_done[%0d]: got %b expected 00", d, {busy_o[d], done_o[d]}); end
      cmp++; if (led_o[d] !== 4'b0001) begin err++; $display("FAIL reset_led[%0d]: got %b expected 0001", d, led_o[d]); end
    end
    $display("reset: outputs checked after release");
  endtask

  task automatic test_basic();
    int base, db, bb, n1, n2, last1, t;
    logic [31:0] s, e;
    s = 32'h0000_0010;
    base = xd.size(); db = done_cnt[0]; bb = busy_cyc[0];
    r1[0] = 1'b1; r2[0] = 1'b1;
    pulse_start(0, s, 8'd3);
    @(negedge clk);
    cmp++; if ({v1[0], v2[0], o1[0], o2[0]} !== {2'b11, s, ~s}) begin
      err++; $display("FAIL basic_latency: got v=%b%b %h/%h expected v=11 %h/%h", v1[0], v2[0], o1[0], o2[0], s, ~s); end
    cmp++; if (led_o[0] !== 4'b0100) begin err++; $display("FAIL basic_led_send: got %b expected 0100", led_o[0]); end
    @(negedge clk);
    cmp++; if ({v1[0], v2[0], led_o[0]} !== {2'b00, 4'b0010}) begin
      err++; $display("FAIL basic_gap: got v=%b%b led=%b expected v=00 led=0010", v1[0], v2[0], led_o[0]); end
    for (t = 0; t < 100 && busy_o[0]; t++) @(negedge clk);
    cmp++; if (busy_o[0]) begin err++; $display("FAIL basic_timeout: busy still %b after %0d cycles expected 0", busy_o[0], t); end
    n1 = 0; n2 = 0; last1 = 0;
    for (int i = base; i < xd.size(); i++) begin
      if (xd[i] == 0 && xc[i] == 1) begin
        e = s + 32'(n1);
        cmp++; if (xdata[i] !== e) begin err++; $display("FAIL basic_out1[%0d]: got %h expected %h", n1, xdata[i], e); end
        if (n1 > 0) begin
          cmp++; if (xcyc[i] - last1 != 5) begin err++; $display("FAIL basic_spacing[%0d]: got %0d expected 5", n1, xcyc[i] - last1); end
        end
        last1 = xcyc[i]; n1++;
      end else if (xd[i] == 0) begin
        e = ~(s + 32'(n2));
        cmp++; if (xdata[i] !== e) begin err++; $display("FAIL basic_out2[%0d]: got %h expected %h", n2, xdata[i], e); end
        n2++;
      end
    end
    cmp++; if (n1 != 3 || n2 != 3) begin err++; $display("FAIL basic_count: got %0d/%0d expected 3/3", n1, n2); end
    cmp++; if (done_cnt[0] - db != 1) begin err++; $display("FAIL basic_done: got %0d expected 1", done_cnt[0] - db); end
    cmp++; if (busy_cyc[0] - bb != 12) begin err++; $display("FAIL basic_duration: got %0d expected 12", busy_cyc[0] - bb); end
    cmp++; if ({led_o[0], done_o[0]} !== {4'b0001, 1'b0}) begin err++; $display("FAIL basic_idle: got led=%b done=%b expected 0001/0", led_o[0], done_o[0]); end
    $display("basic: seed=%h len=3 pairs=%0d", s, n1);
  endtask

  task automatic test_backpressure();
    int base, t, c1p0, c2p0, c1p1, n1;
    logic [31:0] s;
    s = 32'h0000_0010;
    base = xd.size();
    r1[0] = 1'b1; r2[0] = 1'b0;
    pulse_start(0, s, 8'd3);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      cmp++; if ({v2[0], o2[0]} !== {1'b1, 32'hFFFF_FFEF}) begin
        err++; $display("FAIL skew_hold[%0d]: got v=%b %h expected v=1 ffffffef", i, v2[0], o2[0]); end
      cmp++; if (v1[0] !== (i == 0)) begin err++; $display("FAIL skew_v1[%0d]: got %b expected %b", i, v1[0], (i == 0)); end
    end
    @(posedge clk); #1;
    r2[0] = 1'b1;
    for (t = 0; t < 200 && busy_o[0]; t++) @(negedge clk);
    cmp++; if (busy_o[0]) begin err++; $display("FAIL skew_timeout: busy still %b expected 0", busy_o[0]); end
    c1p0 = -1; c2p0 = -1; c1p1 = -1; n1 = 0;
    for (int i = base; i < xd.size(); i++) begin
      if (xd[i] == 0 && xc[i] == 1) begin
        if (n1 == 0) c1p0 = xcyc[i];
        if (n1 == 1) c1p1 = xcyc[i];
        n1++;
      end
      if (xd[i] == 0 && xc[i] == 2 && c2p0 < 0) c2p0 = xcyc[i];
    end
    cmp++; if (c2p0 - c1p0 != 7) begin err++; $display("FAIL skew_ch2_delay: got %0d expected 7", c2p0 - c1p0); end
    cmp++; if (c1p1 - c2p0 != 5) begin err++; $display("FAIL skew_gap_after: got %0d expected 5", c1p1 - c2p0); end
    cmp++; if (n1 != 3) begin err++; $display("FAIL skew_count: got %0d expected 3", n1); end
    $display("backpressure: ch2 delay=%0d next pair after=%0d", c2p0 - c1p0, c1p1 - c2p0);
  endtask

  task automatic test_wrap();
    int base, t, n1;
    logic [31:0] s, e;
    s = 32'hFFFF_FFFE;
    base = xd.size();
    r1[0] = 1'b1; r2[0] = 1'b1;
    pulse_start(0, s, 8'd3);
    for (t = 0; t < 100 && busy_o[0]; t++) @(negedge clk);
    cmp++; if (busy_o[0]) begin err++; $display("FAIL wrap_timeout: busy still %b expected 0", busy_o[0]); end
    n1 = 0;
    for (int i = base; i < xd.size(); i++) begin
      if (xd[i] == 0 && xc[i] == 1) begin
        e = (n1 == 0) ? 32'hFFFF_FFFE : (n1 == 1) ? 32'hFFFF_FFFF : 32'h0000_0000;
        cmp++; if (xdata[i] !== e) begin err++; $display("FAIL wrap_out1[%0d]: got %h expected %h", n1, xdata[i], e); end
        n1++;
      end
    end
    cmp++; if (n1 != 3) begin err++; $display("FAIL wrap_count: got %0d expected 3", n1); end
    $display("wrap: seed=%h pairs=%0d", s, n1);
  endtask

  task automatic test_zero_len();
    int base, db;
    for (int d = 0; d < 2; d++) begin
      base = xd.size(); db = done_cnt[d];
      pulse_start(d, $urandom, 8'd0);
      @(negedge clk);
      cmp++; if ({done_o[d], v1[d], v2[d], led_o[d]} !== {3'b100, 4'b1000}) begin
        err++; $display("FAIL zero_done[%0d]: got done=%b v=%b%b led=%b expected 1 00 1000", d, done_o[d], v1[d], v2[d], led_o[d]); end
      @(negedge clk);
      cmp++; if ({done_o[d], busy_o[d]} !== 2'b00) begin err++; $display("FAIL zero_end[%0d]: got %b expected 00", d, {done_o[d], busy_o[d]}); end
      cmp++; if (xd.size() != base || done_cnt[d] - db != 1) begin
        err++; $display("FAIL zero_traffic[%0d]: got xfers=%0d dones=%0d expected 0/1", d, xd.size() - base, done_cnt[d] - db); end
      $display("zero_len: dut %0d done pulse only", d);
    end
  endtask

  task automatic test_back_to_back();
    int base, db, t, n;
    logic [31:0] s, e;
    s = $urandom;
    base = xd.size(); db = done_cnt[1];
    r1[1] = 1'b1; r2[1] = 1'b1;
    pulse_start(1, s, 8'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = s + 32'(i);
      cmp++; if ({v1[1], v2[1], o1[1], o2[1]} !== {2'b11, e, ~e}) begin
        err++; $display("FAIL b2b_cycle[%0d]: got v=%b%b %h/%h expected 11 %h/%h", i, v1[1], v2[1], o1[1], o2[1], e, ~e); end
      if (i == 1) begin start_v[1] = 1'b1; seed_v[1] = ~s; len_v[1] = 8'd9; end
      if (i == 2) start_v[1] = 1'b0;
    end
    for (t = 0; t < 50 && busy_o[1]; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    cmp++; if (busy_o[1] !== 1'b0) begin err++; $display("FAIL b2b_idle: got busy=%b expected 0", busy_o[1]); end
    n = 0;
    for (int i = base; i < xd.size(); i++) if (xd[i] == 1) n++;
    cmp++; if (n != 8 || done_cnt[1] - db != 1) begin
      err++; $display("FAIL b2b_ignored_start: got xfers=%0d dones=%0d expected 8/1", n, done_cnt[1] - db); end
    $display("back_to_back: seed=%h transfers=%0d", s, n);
  endtask

  task automatic test_random();
    int base, db, se, t, n1, n2, d;
    logic [31:0] s, e;
    logic [7:0]  l;
    for (int it = 0; it < 9; it++) begin
      d = it % 2;
      s = $urandom;
      l = (it == 8) ? 8'd255 : 8'($urandom_range(1, 10));
      if (it == 8) d = 1;
      base = xd.size(); db = done_cnt[d]; se = stab_err;
      pulse_start(d, s, l);
      for (t = 0; t < 4000; t++) begin
        @(posedge clk); #1;
        if (!busy_o[d]) break;
        r1[d] = ($urandom_range(0, 3) != 0);
        r2[d] = ($urandom_range(0, 3) != 0);
      end
      r1[d] = 1'b1; r2[d] = 1'b1;
      cmp++; if (busy_o[d]) begin err++; $display("FAIL rand_timeout[%0d]: busy still %b expected 0", it, busy_o[d]); end
      @(negedge clk);
      n1 = 0; n2 = 0;
      for (int i = base; i < xd.size(); i++) begin
        if (xd[i] != d) continue;
        if (xc[i] == 1) begin
          e = s + 32'(n1);
          cmp++; if (xdata[i] !== e) begin err++; $display("FAIL rand_out1[%0d/%0d]: got %h expected %h", it, n1, xdata[i], e); end
          n1++;
        end else begin
          e = ~(s + 32'(n2));
          cmp++; if (xdata[i] !== e) begin err++; $display("FAIL rand_out2[%0d/%0d]: got %h expected %h", it, n2, xdata[i], e); end
          n2++;
        end
      end
      cmp++; if (n1 != int'(l) || n2 != int'(l)) begin err++; $display("FAIL rand_count[%0d]: got %0d/%0d expected %0d", it, n1, n2, l); end
      cmp++; if (done_cnt[d] - db != 1) begin err++; $display("FAIL rand_done[%0d]: got %0d expected 1", it, done_cnt[d] - db); end
      cmp++; if (stab_err != se) begin err++; $display("FAIL rand_stability[%0d]: got %0d violations expected 0", it, stab_err - se); end
      $display("random[%0d]: dut %0d seed=%h len=%0d pairs=%0d", it, d, s, l, n1);
    end
  endtask

  task automatic test_reset_mid();
    int base, db, t, n1;
    logic [31:0] s, e;
    s = $urandom;
    db = done_cnt[0];
    r1[0] = 1'b1; r2[0] = 1'b1;
    pulse_start(0, s, 8'd5);
    repeat (6) @(negedge clk);
    e = s + 32'd1;
    cmp++; if ({v1[0], o1[0]} !== {1'b1, e}) begin err++; $display("FAIL mid_pair1: got v=%b %h expected 1 %h", v1[0], o1[0], e); end
    #1 reset = 1'b1;
    #1;
    cmp++; if ({v1[0], v2[0], busy_o[0], led_o[0]} !== {3'b000, 4'b0001}) begin
      err++; $display("FAIL mid_abort: got v=%b%b busy=%b led=%b expected 00 0 0001", v1[0], v2[0], busy_o[0], led_o[0]); end
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    cmp++; if (done_cnt[0] != db) begin err++; $display("FAIL mid_no_done: got %0d pulses expected 0", done_cnt[0] - db); end
    s = $urandom;
    base = xd.size();
    pulse_start(0, s, 8'd2);
    for (t = 0; t < 100 && busy_o[0]; t++) @(negedge clk);
    n1 = 0;
    for (int i = base; i < xd.size(); i++) begin
      if (xd[i] == 0 && xc[i] == 1) begin
        e = s + 32'(n1);
        cmp++; if (xdata[i] !== e) begin err++; $display("FAIL mid_restart[%0d]: got %h expected %h", n1, xdata[i], e); end
        n1++;
      end
    end
    cmp++; if (n1 != 2 || done_cnt[0] - db != 1) begin err++; $display("FAIL mid_restart_count: got %0d/%0d expected 2/1", n1, done_cnt[0] - db); end
    $display("reset_mid: aborted then restarted seed=%h pairs=%0d", s, n1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
